// File: rtl/lambda_pe_ctrl.sv
// Weight/iact sequencer for a chain of lambda PEs. Loads weight set n+1 into the
// shadow ping/pong bank while set n is computed from the active bank.
module lambda_pe_ctrl #(
    parameter int NUM_PE             = 4,
    parameter int DATA_WIDTH         = 8,
    parameter int WEIGHTS_DEPTH      = 16,
    parameter int LOG2_WEIGHTS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_cfg_valid,
    input  logic [LOG2_WEIGHTS_DEPTH-1:0] i_cfg_k,
    input  logic [15:0]                   i_cfg_passes,
    input  logic [7:0]                    i_cfg_sets,
    input  logic [DATA_WIDTH-1:0]         i_w_data,
    input  logic                          i_w_valid,
    output logic                          o_w_ready,
    input  logic [DATA_WIDTH-1:0]         i_a_data,
    input  logic                          i_a_valid,
    output logic                          o_a_ready,
    output logic [DATA_WIDTH-1:0]         o_weights,
    output logic [LOG2_WEIGHTS_DEPTH-1:0] o_weights_addr,
    output logic                          o_weights_valid,
    output logic [LOG2_WEIGHTS_DEPTH-1:0] o_pe_sel,
    output logic                          o_weights_ping_pong_sel,
    output logic [DATA_WIDTH-1:0]         o_iacts,
    output logic                          o_iacts_valid,
    output logic [LOG2_WEIGHTS_DEPTH-1:0] o_weights_sel_for_iacts_use,
    output logic [LOG2_WEIGHTS_DEPTH-1:0] o_weights_to_use,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int AW = LOG2_WEIGHTS_DEPTH;
    localparam logic [AW-1:0] MAX_K   = AW'(WEIGHTS_DEPTH - 1);
    localparam logic [AW-1:0] LAST_PE = AW'(NUM_PE - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_RUN, S_SWAP, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         k_q, k_d;
    logic [15:0]           passes_q, passes_d, pass_cnt_q, pass_cnt_d;
    logic [7:0]            sets_q, sets_d, set_cnt_q, set_cnt_d;
    logic [AW-1:0]         w_cnt_q, w_cnt_d, pe_cnt_q, pe_cnt_d, a_cnt_q, a_cnt_d;
    logic                  w_loaded_q, w_loaded_d, a_done_q, a_done_d;
    logic                  sel_q, sel_d;
    logic [1:0]            phase_q, phase_d;
    logic [DATA_WIDTH-1:0] weights_q, weights_d, iacts_q, iacts_d;
    logic [AW-1:0]         waddr_q, waddr_d, pe_sel_q, pe_sel_d, a_sel_q, a_sel_d;
    logic                  wvalid_q, wvalid_d, avalid_q, avalid_d, done_q, done_d;
    logic                  w_ready, a_ready, w_fire, a_fire;

    always_comb begin
        w_ready = (state_q == S_PRELOAD) ||
                  ((state_q == S_RUN) && (set_cnt_q != sets_q) && !w_loaded_q);
        a_ready = (state_q == S_RUN) && !a_done_q;
        w_fire  = i_w_valid && w_ready;
        a_fire  = i_a_valid && a_ready;

        state_d    = state_q;
        k_d        = k_q;
        passes_d   = passes_q;
        sets_d     = sets_q;
        pass_cnt_d = pass_cnt_q;
        set_cnt_d  = set_cnt_q;
        w_cnt_d    = w_cnt_q;
        pe_cnt_d   = pe_cnt_q;
        a_cnt_d    = a_cnt_q;
        w_loaded_d = w_loaded_q;
        a_done_d   = a_done_q;
        sel_d      = sel_q;
        phase_d    = phase_q;
        weights_d  = weights_q;
        waddr_d    = waddr_q;
        pe_sel_d   = pe_sel_q;
        iacts_d    = iacts_q;
        a_sel_d    = a_sel_q;
        wvalid_d   = w_fire;
        avalid_d   = a_fire;
        done_d     = 1'b0;

        // Load side: PE-major walk, addr 0..K then next PE.
        if (w_fire) begin
            weights_d = i_w_data;
            waddr_d   = w_cnt_q;
            pe_sel_d  = pe_cnt_q;
            if (w_cnt_q == k_q) begin
                w_cnt_d = '0;
                if (pe_cnt_q == LAST_PE) begin
                    pe_cnt_d   = '0;
                    w_loaded_d = 1'b1;
                end else begin
                    pe_cnt_d = pe_cnt_q + 1'b1;
                end
            end else begin
                w_cnt_d = w_cnt_q + 1'b1;
            end
        end

        if (a_fire) begin
            iacts_d = i_a_data;
            a_sel_d = a_cnt_q;
            if (a_cnt_q == k_q) begin
                a_cnt_d = '0;
                if (pass_cnt_q == passes_q) a_done_d = 1'b1;
                else                        pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
                a_cnt_d = a_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_cfg_valid) begin
                    // Saturate K so a non-power-of-two depth can never overrun the buffer.
                    k_d        = (i_cfg_k > MAX_K) ? MAX_K : i_cfg_k;
                    passes_d   = i_cfg_passes;
                    sets_d     = i_cfg_sets;
                    pass_cnt_d = '0;
                    set_cnt_d  = '0;
                    w_cnt_d    = '0;
                    pe_cnt_d   = '0;
                    a_cnt_d    = '0;
                    w_loaded_d = 1'b0;
                    a_done_d   = 1'b0;
                    sel_d      = 1'b0;
                    phase_d    = '0;
                    state_d    = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (w_fire && (w_cnt_q == k_q) && (pe_cnt_q == LAST_PE)) begin
                    phase_d = '0;
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                if (phase_q == 2'd1) begin
                    sel_d      = ~sel_q;
                    a_cnt_d    = '0;
                    pass_cnt_d = '0;
                    a_done_d   = 1'b0;
                    w_cnt_d    = '0;
                    pe_cnt_d   = '0;
                    w_loaded_d = 1'b0;
                    phase_d    = '0;
                    state_d    = S_RUN;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_RUN: begin
                if (a_done_q) begin
                    if (set_cnt_q == sets_q) begin
                        phase_d = '0;
                        state_d = S_DRAIN;
                    end else if (w_loaded_q) begin
                        set_cnt_d = set_cnt_q + 1'b1;
                        phase_d   = '0;
                        state_d   = S_SWAP;
                    end
                end
            end
            S_DRAIN: begin
                if (phase_q == 2'd3) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            passes_q   <= '0;
            sets_q     <= '0;
            pass_cnt_q <= '0;
            set_cnt_q  <= '0;
            w_cnt_q    <= '0;
            pe_cnt_q   <= '0;
            a_cnt_q    <= '0;
            w_loaded_q <= 1'b0;
            a_done_q   <= 1'b0;
            sel_q      <= 1'b0;
            phase_q    <= '0;
            weights_q  <= '0;
            waddr_q    <= '0;
            pe_sel_q   <= '0;
            iacts_q    <= '0;
            a_sel_q    <= '0;
            wvalid_q   <= 1'b0;
            avalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            passes_q   <= passes_d;
            sets_q     <= sets_d;
            pass_cnt_q <= pass_cnt_d;
            set_cnt_q  <= set_cnt_d;
            w_cnt_q    <= w_cnt_d;
            pe_cnt_q   <= pe_cnt_d;
            a_cnt_q    <= a_cnt_d;
            w_loaded_q <= w_loaded_d;
            a_done_q   <= a_done_d;
            sel_q      <= sel_d;
            phase_q    <= phase_d;
            weights_q  <= weights_d;
            waddr_q    <= waddr_d;
            pe_sel_q   <= pe_sel_d;
            iacts_q    <= iacts_d;
            a_sel_q    <= a_sel_d;
            wvalid_q   <= wvalid_d;
            avalid_q   <= avalid_d;
            done_q     <= done_d;
        end
    end

    assign o_w_ready                   = w_ready;
    assign o_a_ready                   = a_ready;
    assign o_weights                   = weights_q;
    assign o_weights_addr              = waddr_q;
    assign o_weights_valid             = wvalid_q;
    assign o_pe_sel                    = pe_sel_q;
    assign o_weights_ping_pong_sel     = sel_q;
    assign o_iacts                     = iacts_q;
    assign o_iacts_valid               = avalid_q;
    assign o_weights_sel_for_iacts_use = a_sel_q;
    assign o_weights_to_use            = k_q;
    assign o_busy                      = (state_q != S_IDLE);
    assign o_done                      = done_q;

endmodule

// File: tb/tb_lambda_pe_ctrl.sv
// Scoreboard bench for lambda_pe_ctrl: drivers push expected PE writes/iacts,
// a monitor pops and compares whenever the DUT presents a valid output.
module tb_lambda_pe_ctrl;
    localparam int NUM_PE = 4;
    localparam int DW     = 8;
    localparam int AW     = 4;

    logic          clk, rst_n;
    logic          i_cfg_valid;
    logic [AW-1:0] i_cfg_k;
    logic [15:0]   i_cfg_passes;
    logic [7:0]    i_cfg_sets;
    logic [DW-1:0] i_w_data, i_a_data;
    logic          i_w_valid, i_a_valid, o_w_ready, o_a_ready;
    logic [DW-1:0] o_weights, o_iacts;
    logic [AW-1:0] o_weights_addr, o_pe_sel, o_weights_sel_for_iacts_use, o_weights_to_use;
    logic          o_weights_valid, o_weights_ping_pong_sel, o_iacts_valid, o_busy, o_done;

    lambda_pe_ctrl #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .WEIGHTS_DEPTH(16),
                     .LOG2_WEIGHTS_DEPTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_cfg_valid(i_cfg_valid), .i_cfg_k(i_cfg_k),
        .i_cfg_passes(i_cfg_passes), .i_cfg_sets(i_cfg_sets),
        .i_w_data(i_w_data), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
        .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .o_weights(o_weights), .o_weights_addr(o_weights_addr),
        .o_weights_valid(o_weights_valid), .o_pe_sel(o_pe_sel),
        .o_weights_ping_pong_sel(o_weights_ping_pong_sel), .o_iacts(o_iacts),
        .o_iacts_valid(o_iacts_valid),
        .o_weights_sel_for_iacts_use(o_weights_sel_for_iacts_use),
        .o_weights_to_use(o_weights_to_use), .o_busy(o_busy), .o_done(o_done));

    typedef struct { logic [DW-1:0] d; logic [AW-1:0] addr; logic [AW-1:0] pe; logic bank; } wexp_t;
    typedef struct { logic [DW-1:0] d; logic [AW-1:0] sel; logic bank; } aexp_t;
    wexp_t wq[$];
    aexp_t aq[$];
    wexp_t we, wgot;
    aexp_t ae, agot;

    int n_assert = 0, n_fail = 0;
    int cyc = 0;
    int cur_k = 0, cur_p = 0;
    int w_todo = 0, a_todo = 0, w_sent = 0, a_sent = 0, w_prob = 100, a_prob = 100;
    int w_seen = 0, a_seen = 0, done_cnt = 0, toggles = 0, toggle_cyc = 0;
    int last_w_cyc = 0, last_a_out_cyc = 0, stall_at = 0;
    bit stall_en = 0;
    logic prev_sel = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Weight feeder: expected PE/addr/bank follow from the beat index alone.
    initial forever begin
        @(negedge clk);
        i_w_valid = rst_n && (w_todo > 0) && !(stall_en && w_sent == stall_at) &&
                    (int'($urandom_range(0, 99)) < w_prob);
        i_w_data = DW'($urandom);
        if (i_w_valid && o_w_ready) begin
            we.d    = i_w_data;
            we.addr = AW'(w_sent % (cur_k + 1));
            we.pe   = AW'((w_sent / (cur_k + 1)) % NUM_PE);
            we.bank = 1'((w_sent / ((cur_k + 1) * NUM_PE)) % 2);
            wq.push_back(we);
            w_sent++;
            w_todo--;
            last_w_cyc = cyc;
        end
    end

    // Iact feeder: set s computes from bank s%2, so sel reads (s+1)%2 meanwhile.
    initial forever begin
        @(negedge clk);
        i_a_valid = rst_n && (a_todo > 0) && (int'($urandom_range(0, 99)) < a_prob);
        i_a_data  = DW'($urandom);
        if (i_a_valid && o_a_ready) begin
            ae.d    = i_a_data;
            ae.sel  = AW'(a_sent % (cur_k + 1));
            ae.bank = 1'(((a_sent / ((cur_k + 1) * (cur_p + 1))) + 1) % 2);
            aq.push_back(ae);
            a_sent++;
            a_todo--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (o_weights_valid) begin
                w_seen++;
                if (wq.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    wgot = wq.pop_front();
                    chk("w_data", o_weights, wgot.d);
                    chk("w_addr", o_weights_addr, wgot.addr);
                    chk("w_pe_sel", o_pe_sel, wgot.pe);
                    chk("w_bank", o_weights_ping_pong_sel, wgot.bank);
                end
            end
            if (o_iacts_valid) begin
                a_seen++;
                last_a_out_cyc = cyc;
                if (aq.size() == 0) chk("a_unexpected", 1, 0);
                else begin
                    agot = aq.pop_front();
                    chk("a_data", o_iacts, agot.d);
                    chk("a_sel", o_weights_sel_for_iacts_use, agot.sel);
                    chk("a_bank", o_weights_ping_pong_sel, agot.bank);
                end
            end
            if (o_done) begin
                done_cnt++;
                chk("done_latency", cyc - last_a_out_cyc, 5);
            end
            if (o_weights_ping_pong_sel != prev_sel) begin
                toggles++;
                toggle_cyc = cyc;
            end
        end
        prev_sel = o_weights_ping_pong_sel;
    end

    task automatic start_cfg(input int k, input int p, input int s, input int wp, input int ap);
        @(negedge clk);
        cur_k = k; cur_p = p; w_prob = wp; a_prob = ap;
        w_sent = 0; a_sent = 0; w_seen = 0; a_seen = 0; done_cnt = 0;
        w_todo = NUM_PE * (k + 1) * (s + 1);
        a_todo = (k + 1) * (p + 1) * (s + 1);
        i_cfg_k = AW'(k); i_cfg_passes = 16'(p); i_cfg_sets = 8'(s);
        i_cfg_valid = 1'b1;
        @(negedge clk);
        i_cfg_valid = 1'b0;
        #1 toggles = 0;
    endtask

    task automatic run_cfg(input int k, input int p, input int s, input int wp, input int ap,
                           input bit stall, input bit poke);
        start_cfg(k, p, s, wp, ap);
        chk("busy_after_cfg", o_busy, 1);
        if (stall) begin
            stall_at = NUM_PE * (k + 1) + 10;
            stall_en = 1;
            for (int i = 0; i < 2000 && w_sent < stall_at; i++) @(negedge clk);
            chk("stall_reached", w_sent, stall_at);
            repeat (30) @(negedge clk);
            chk("stall_a_ready", o_a_ready, 0);
            chk("stall_no_toggle", toggles, 1);
            chk("stall_busy", o_busy, 1);
            stall_en = 0;
            for (int i = 0; i < 2000 && (w_todo > 0 || toggles < 2); i++) @(negedge clk);
            chk("stall_swap_cycle", toggle_cyc - last_w_cyc, 4);
        end
        if (poke) begin
            for (int i = 0; i < 2000 && a_sent == 0; i++) @(negedge clk);
            @(negedge clk);
            i_cfg_k = 4'd9; i_cfg_passes = 16'd7; i_cfg_sets = 8'd5;
            i_cfg_valid = 1'b1;
            @(negedge clk);
            i_cfg_valid = 1'b0;
        end
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("w_count", w_seen, NUM_PE * (k + 1) * (s + 1));
        chk("a_count", a_seen, (k + 1) * (p + 1) * (s + 1));
        chk("swaps", toggles, s + 1);
        chk("bank_end", o_weights_ping_pong_sel, (s + 1) % 2);
        chk("weights_to_use", o_weights_to_use, k);
        chk("idle_busy", o_busy, 0);
        chk("queues_empty", wq.size() + aq.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1; i_cfg_valid = 1'b0; i_cfg_k = '0; i_cfg_passes = '0; i_cfg_sets = '0;
        i_w_data = '0; i_w_valid = 1'b0; i_a_data = '0; i_a_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", {o_w_ready, o_a_ready}, 0);
        chk("rst_valid", {o_weights_valid, o_iacts_valid, o_done}, 0);
        chk("rst_bank", o_weights_ping_pong_sel, 0);
        chk("rst_data", {o_weights, o_iacts, o_weights_addr, o_pe_sel}, 0);
        chk("rst_misc", {o_weights_sel_for_iacts_use, o_weights_to_use}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cfg(3, 1, 0, 100, 100, 0, 0);
        run_cfg(3, 1, 1, 100, 100, 0, 0);
        run_cfg(3, 1, 1, 100, 100, 1, 0);
        run_cfg(3, 2, 1, 100, 100, 0, 1);
        run_cfg(0, 0, 0, 100, 100, 0, 0);
        for (int t = 0; t < 4; t++)
            run_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(40, 90)),
                    int'($urandom_range(30, 90)), 0, 0);

        start_cfg(3, 3, 2, 100, 100);
        for (int i = 0; i < 2000 && a_sent < 5; i++) @(negedge clk);
        chk("mid_run_reached", a_sent >= 5, 1);
        @(posedge clk);
        #2;
        w_todo = 0; a_todo = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", {o_w_ready, o_a_ready}, 0);
        chk("mid_rst_valid", {o_weights_valid, o_iacts_valid, o_done}, 0);
        chk("mid_rst_bank", o_weights_ping_pong_sel, 0);
        wq.delete();
        aq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, 0);
        run_cfg(1, 0, 0, 100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lambda_pe_ctrl.md
# lambda_pe_ctrl

Sequencer for a chain of `NUM_PE` lambda PEs: loads weights into each PE's ping/pong local buffer and streams input activations with the matching weight-select index. The load of weight set n+1 into the shadow bank overlaps compute of set n on the active bank. The block sits between the upstream weight/iact feeders (valid/ready) and PE 0 of the chain, and drives the PE's weight, iact and select inputs directly.

## Interface
- `NUM_PE`, 4: PEs in the chain; ids 0..NUM_PE-1.
- `DATA_WIDTH`, 8: weight/iact width.
- `WEIGHTS_DEPTH`, 16: per-PE buffer depth per bank.
- `LOG2_WEIGHTS_DEPTH`, 4: address/select width; also the width of `o_pe_sel`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_cfg_valid` in 1: start pulse; sampled only in S_IDLE.
- `i_cfg_k` in LOG2_WEIGHTS_DEPTH: weights per PE minus 1 (K-1).
- `i_cfg_passes` in 16: output windows per weight set minus 1.
- `i_cfg_sets` in 8: weight sets minus 1.
- `i_w_data` in DATA_WIDTH, `i_w_valid` in 1, `o_w_ready` out 1: weight stream.
- `i_a_data` in DATA_WIDTH, `i_a_valid` in 1, `o_a_ready` out 1: iact stream.
- `o_weights` out DATA_WIDTH, `o_weights_addr` out LOG2_WEIGHTS_DEPTH, `o_weights_valid` out 1, `o_pe_sel` out LOG2_WEIGHTS_DEPTH: PE weight-write port.
- `o_weights_ping_pong_sel` out 1: PEs write bank `sel` and compute from the other bank.
- `o_iacts` out DATA_WIDTH, `o_iacts_valid` out 1, `o_weights_sel_for_iacts_use` out LOG2_WEIGHTS_DEPTH: iact stream to PE 0.
- `o_weights_to_use` out LOG2_WEIGHTS_DEPTH: registered `i_cfg_k`.
- `o_busy` out 1, `o_done` out 1: status; `o_done` is a one-cycle pulse.

## Operation
- States: S_IDLE, S_PRELOAD, S_RUN, S_SWAP, S_DRAIN.
- S_IDLE: on `i_cfg_valid`, latch cfg, clear counters, go to S_PRELOAD.
- S_PRELOAD: `o_w_ready`=1. Load NUM_PE*(K) weights into bank `o_weights_ping_pong_sel`.
  - Order: PE 0 addr 0..K-1, then PE 1, and so on.
  - After the last accepted weight, go to S_SWAP.
- S_SWAP: fixed 2 cycles, all readies 0. On exit, toggle `o_weights_ping_pong_sel` and go to S_RUN.
- S_RUN, compute side:
  - `o_a_ready`=1 until passes+1 windows of K iacts are accepted.
  - `a_cnt` counts 0..K-1 and wraps; each wrap increments the pass counter.
- S_RUN, load side:
  - If sets remain, `o_w_ready`=1 until the next set is fully loaded into the shadow bank.
  - The load side is independent of the compute side.
- S_RUN exit:
  - Compute complete, more sets remain, next set loaded: go to S_SWAP; set counter +1.
  - Compute complete and this was the last set: go to S_DRAIN.
  - Compute complete but next set not yet loaded: hold with `o_a_ready`=0.
- S_DRAIN: 4 cycles, covering PE MAC latency. Then pulse `o_done`, go to S_IDLE.
- `o_busy`=1 in every state except S_IDLE.
- `i_cfg_valid` outside S_IDLE is ignored.
- Counters are minus-one encoded, so cfg value 0 means one set, one pass, or one weight.

## Timing
- Reset values: all outputs 0, including `o_weights_ping_pong_sel`. State S_IDLE.
- Handshake: a transfer occurs on the edge where valid&ready=1.
  - Ready is registered-state only; it never depends combinationally on valid.
  - Valid may drop between beats; counters advance only on a transfer.
- Weight beat accepted at cycle t: `o_weights`, `o_weights_addr` (= w_cnt) and `o_pe_sel` (= pe_cnt) are held at t+1 with `o_weights_valid`=1. Otherwise `o_weights_valid`=0.
- Iact beat accepted at cycle t: `o_iacts` and `o_weights_sel_for_iacts_use` (= a_cnt) are held at t+1 with `o_iacts_valid`=1. Otherwise `o_iacts_valid`=0.
- The bank toggles only at S_SWAP exit. At least 2 idle cycles separate the last iact output from the toggle, and no weight write is in flight.
- A load and an iact transfer in the same cycle are legal and handled independently.
- `o_done` is asserted exactly the cycle after the 4th S_DRAIN cycle.
- `rst_n` low mid-operation: immediate return to reset values. In-flight beats are discarded; no `o_done`.

## Test plan
- **Single set.** NUM_PE=4, k=3, passes=1, sets=0; feed 16 weights, then 8 iacts.
  - 16 writes: PE 0..3, addr 0..3 each, bank 0; then `o_weights_ping_pong_sel`=1.
  - Sel sequence 0,1,2,3,0,1,2,3.
  - `o_done` pulses 5 cycles after the last iact output.
- **Overlap.** sets=1; weights always valid.
  - Second-set writes go to bank 1 while iacts stream on the active bank.
  - Second S_SWAP toggles sel back to 0.
  - Total 32 weight writes and 16 iact outputs.
- **Load stall.** sets=1; hold `i_w_valid`=0 after 10 second-set weights.
  - `o_a_ready` drops once compute completes; no toggle.
  - Resume weights: S_SWAP follows the 16th weight.
- **Bubbles.** Random valid gaps on both streams.
  - Output count, order, addr/sel and pe_sel values are unchanged; valid outputs occur only one cycle after transfers.
- **Config rules.** `i_cfg_valid` pulsed during S_RUN is ignored. Config all zeros gives 4 weights, 1 iact, then `o_done`.
- **Reset mid-run.** Assert `rst_n` low during S_RUN.
  - All outputs 0 and `o_busy`=0 with no clock edge.
  - A new cfg afterwards restarts with bank sel=0.
